t03_mem_writeback: RTL and testbench
====================================

Name: t03_mem_writeback

Overview:
- Memory/writeback stage directly upstream of t03_register_file. Accepts one retired execute-stage operation at a time.
- For ALU ops, forwards the result. For loads/stores, runs a single-transaction data-memory handshake with byte-lane alignment and load sign/zero extension.
- Drives rd_address, register_write_en and register_write_data into the register file.
- Back-pressures execute via ex_ready while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ack before abort. Used only with T03_MEM_TIMEOUT_EN.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  global stage enable (same enable that feeds the register file)
- ex_valid  in  1  execute op presented
- ex_ready  out  1  stage can accept; equals (state==IDLE) && en
- ex_is_load  in  1  op is load
- ex_is_store  in  1  op is store
- ex_funct3  in  3  RV32 load/store width code
- ex_rd  in  5  destination register
- ex_alu_result  in  32  ALU result / effective address
- ex_store_data  in  32  rs2 value for stores
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_sel  out  4  byte-lane strobes
- mem_read  out  1  read request, level
- mem_write  out  1  write request, level
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  single-cycle completion
- rd_address  out  5  to register file
- register_write_en  out  1  to register file
- register_write_data  out  32  to register file
- misalign_err  out  1  one-cycle error pulse
- bus_err  out  1  one-cycle timeout pulse (0 when feature off)

Behaviour:
- Reset (nrst=0, async): state=IDLE; all outputs 0; all latches (rd, data, address, funct3) 0; ack_pending=0.
- Accept: ex_valid && ex_ready at a clock edge. The op fields are latched.
- States:
  - IDLE
  - MEM
  - WB
- IDLE transitions on accept:
  - ALU op (neither load nor store) -> WB, latching data=ex_alu_result.
  - Load/store -> MEM if legal and aligned.
  - Otherwise stay in IDLE and pulse misalign_err the next cycle; there is no bus access and no write.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
- Alignment rules:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Any other funct3 is treated as a misalign_err.
- MEM:
  - mem_read or mem_write is held high, and mem_addr/mem_sel/mem_wdata are held stable, until the cycle mem_ack=1.
  - On ack, a load -> WB with the extended data latched; a store -> IDLE.
  - Requests deassert in the cycle after ack.
- Store lanes:
  - SB: sel=0001<<addr[1:0], wdata=byte replicated x4.
  - SH: sel=0011<<{addr[1],0}, wdata=half replicated x2.
  - SW: sel=1111.
- Load extraction: data shifted right by addr[1:0]*8. LB/LH sign-extend; LBU/LHU zero-extend.
- WB:
  - register_write_en=1 for exactly one enabled cycle, with rd_address and register_write_data valid. Then -> IDLE.
  - register_write_en is forced 0 when rd=0.
- Latency:
  - ALU op: write pulse in cycle N+1 after the accept at edge N.
  - Load: request in N+1; write pulse in the cycle after ack.
- en=0:
  - State, latches and outputs are frozen; no accept occurs.
  - mem_ack arriving in MEM is captured in ack_pending along with the read data. It is consumed when en returns, so the ack is never lost.
  - register_write_en stays high but the register file ignores it; the pulse completes on the first enabled cycle.
- Reset mid-MEM: requests drop immediately (async). The op is discarded and no write occurs.
- Simultaneous: ex_ready=0 in MEM/WB, so there is never an accept while busy.

Optional Feature:
- T03_MEM_TIMEOUT_EN defined:
  - A counter runs in MEM, counting cycles without mem_ack.
  - When the count reaches TIMEOUT_CYCLES: requests drop, bus_err pulses one cycle, -> IDLE, and no register write occurs.
  - An ack in the same cycle the limit is reached wins; the op completes normally.
- T03_MEM_TIMEOUT_EN undefined: no counter, bus_err tied 0, and MEM waits indefinitely.

Decomposition:
- Package t03_mem_wb_pkg:
  - State enum (IDLE, MEM, WB).
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Width localparams.
- Sub-module t03_lsu_align (combinational):
  - Inputs: funct3, addr[1:0], store data, read data.
  - Outputs: mem_sel, mem_wdata, extended load data, misaligned flag.
- The top holds the FSM, latches, ack_pending and the optional timeout counter.

Test Plan:
- ALU op with rd=5, result 0x1234_5678, en=1 -> register_write_en=1 one cycle later with rd_address=5 and data 0x12345678. ex_ready is low for 1 cycle.
- LB at addr 0x103, mem_rdata=0x80AA_BBCC, ack after 3 cycles -> mem_addr=0x100, mem_sel=1111, mem_read held 3 cycles, write data 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at addr 0x202, store_data=0xDEAD_BEEF -> mem_sel=1100, mem_wdata=0xBEEFBEEF, mem_write held until ack, no register write.
- LW at addr 0x0000_0006 -> misalign_err pulses once, no mem_read, no register write, ex_ready=1 the next cycle.
- LW with en dropped while mem_ack arrives (rdata 0xCAFEF00D), en restored 2 cycles later -> write of 0xCAFEF00D on the first enabled WB cycle. ALU op with rd=0 -> register_write_en stays 0.
- With T03_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load with no ack -> mem_read high 4 cycles, bus_err pulses, no write, back to IDLE. Separately, nrst asserted mid-MEM drops mem_read asynchronously.

Source files
------------

// File: rtl/t03_mem_wb_pkg.sv
// Shared types and constants for the t03 memory/writeback stage.
// Used by t03_mem_writeback (optional timeout enabled by T03_MEM_TIMEOUT_EN).
package t03_mem_wb_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned FUNCT3_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

endpackage

// File: rtl/t03_lsu_align.sv
// Combinational byte-lane steering for stores, load extraction/extension,
// and funct3 legality/alignment check.
module t03_lsu_align
    import t03_mem_wb_pkg::*;
(
    input  logic [FUNCT3_W-1:0] funct3_i,
    input  logic [1:0]          addr_lo_i,
    input  logic                is_store_i,
    input  logic [XLEN-1:0]     store_data_i,
    input  logic [XLEN-1:0]     rdata_i,
    output logic [3:0]          sel_o,
    output logic [XLEN-1:0]     wdata_o,
    output logic [XLEN-1:0]     load_data_o,
    output logic                misaligned_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted      = rdata_i >> {addr_lo_i, 3'b000};
        sel_o        = '1;
        wdata_o      = store_data_i;
        load_data_o  = '0;
        misaligned_o = 1'b1;
        case (funct3_i)
            F3_B: begin
                if (is_store_i) sel_o = 4'b0001 << addr_lo_i;
                wdata_o      = {4{store_data_i[7:0]}};
                load_data_o  = {{24{shifted[7]}}, shifted[7:0]};
                misaligned_o = 1'b0;
            end
            F3_H: begin
                if (is_store_i) sel_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o      = {2{store_data_i[15:0]}};
                load_data_o  = {{16{shifted[15]}}, shifted[15:0]};
                misaligned_o = addr_lo_i[0];
            end
            F3_W: begin
                load_data_o  = rdata_i;
                misaligned_o = |addr_lo_i;
            end
            // Unsigned widths exist only for loads; as a store they are illegal.
            F3_BU: begin
                load_data_o  = {24'b0, shifted[7:0]};
                misaligned_o = is_store_i;
            end
            F3_HU: begin
                load_data_o  = {16'b0, shifted[15:0]};
                misaligned_o = is_store_i | addr_lo_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/t03_mem_writeback.sv
// Memory/writeback stage: forwards ALU results, runs one data-memory access
// at a time and drives the register-file write port. T03_MEM_TIMEOUT_EN adds an ack timeout.
module t03_mem_writeback
    import t03_mem_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                en,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                ex_is_load,
    input  logic                ex_is_store,
    input  logic [FUNCT3_W-1:0] ex_funct3,
    input  logic [REG_AW-1:0]   ex_rd,
    input  logic [XLEN-1:0]     ex_alu_result,
    input  logic [XLEN-1:0]     ex_store_data,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [3:0]          mem_sel,
    output logic                mem_read,
    output logic                mem_write,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_ack,
    output logic [REG_AW-1:0]   rd_address,
    output logic                register_write_en,
    output logic [XLEN-1:0]     register_write_data,
    output logic                misalign_err,
    output logic                bus_err
);

    state_e                state_q, state_d;
    logic [REG_AW-1:0]     rd_q, rd_d;
    logic [XLEN-1:0]       addr_q, addr_d, data_q, data_d;
    logic [FUNCT3_W-1:0]   funct3_q, funct3_d;
    logic                  is_load_q, is_load_d;
    logic                  ack_pending_q, ack_pending_d;
    logic                  misalign_q, misalign_d;

    logic                  in_idle, req;
    logic [3:0]            al_sel;
    logic [XLEN-1:0]       al_wdata, al_load;
    logic                  al_misaligned;

    assign in_idle = (state_q == ST_IDLE);
    assign req     = (state_q == ST_MEM) && !ack_pending_q;

    // data_q holds store data during a store and the raw read data while an ack
    // is parked by en=0, so one aligner serves both the accept check and the bus.
    t03_lsu_align u_align (
        .funct3_i     (in_idle ? ex_funct3 : funct3_q),
        .addr_lo_i    (in_idle ? ex_alu_result[1:0] : addr_q[1:0]),
        .is_store_i   (in_idle ? ex_is_store : !is_load_q),
        .store_data_i (in_idle ? ex_store_data : data_q),
        .rdata_i      (ack_pending_q ? data_q : mem_rdata),
        .sel_o        (al_sel),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load),
        .misaligned_o (al_misaligned)
    );

    assign ex_ready            = in_idle && en;
    assign mem_read            = req && is_load_q;
    assign mem_write           = req && !is_load_q;
    assign mem_addr            = req ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_sel             = req ? al_sel : '0;
    assign mem_wdata           = (req && !is_load_q) ? al_wdata : '0;
    assign rd_address          = rd_q;
    assign register_write_en   = (state_q == ST_WB) && (rd_q != '0);
    assign register_write_data = (state_q == ST_WB) ? data_q : '0;
    assign misalign_err        = misalign_q;

`ifdef T03_MEM_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;
    assign bus_err = bus_err_q;
`else
    logic [TO_W-1:0] unused_to_limit;
    assign unused_to_limit = TO_W'(TIMEOUT_CYCLES);
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        rd_d          = rd_q;
        addr_d        = addr_q;
        data_d        = data_q;
        funct3_d      = funct3_q;
        is_load_d     = is_load_q;
        ack_pending_d = ack_pending_q;
        misalign_d    = misalign_q;
`ifdef T03_MEM_TIMEOUT_EN
        cnt_d         = cnt_q;
        bus_err_d     = bus_err_q;
`endif
        if (en) begin
            misalign_d = 1'b0;
`ifdef T03_MEM_TIMEOUT_EN
            bus_err_d  = 1'b0;
`endif
            case (state_q)
                ST_IDLE: if (ex_valid) begin
                    rd_d      = ex_rd;
                    addr_d    = ex_alu_result;
                    funct3_d  = ex_funct3;
                    is_load_d = ex_is_load;
                    if (!(ex_is_load || ex_is_store)) begin
                        data_d  = ex_alu_result;
                        state_d = ST_WB;
                    end else if (al_misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        data_d  = ex_store_data;
                        state_d = ST_MEM;
`ifdef T03_MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
                ST_MEM: begin
                    if (ack_pending_q || mem_ack) begin
                        ack_pending_d = 1'b0;
                        if (is_load_q) begin
                            data_d  = al_load;
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
`ifdef T03_MEM_TIMEOUT_EN
                    else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ST_IDLE;
                        bus_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
                ST_WB:   state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else if ((state_q == ST_MEM) && mem_ack && !ack_pending_q) begin
            ack_pending_d = 1'b1;
            if (is_load_q) data_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= ST_IDLE;
            rd_q          <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            funct3_q      <= '0;
            is_load_q     <= 1'b0;
            ack_pending_q <= 1'b0;
            misalign_q    <= 1'b0;
`ifdef T03_MEM_TIMEOUT_EN
            cnt_q         <= '0;
            bus_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            funct3_q      <= funct3_d;
            is_load_q     <= is_load_d;
            ack_pending_q <= ack_pending_d;
            misalign_q    <= misalign_d;
`ifdef T03_MEM_TIMEOUT_EN
            cnt_q         <= cnt_d;
            bus_err_q     <= bus_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_t03_mem_writeback.sv
// Self-checking bench for t03_mem_writeback: directed cases plus randomized ops
// against a behavioural model. Build with T03_MEM_TIMEOUT_EN to cover the timeout.
module tb_t03_mem_writeback;

`ifdef T03_MEM_TIMEOUT_EN
    localparam int unsigned TO_CYC = 4;
`else
    localparam int unsigned TO_CYC = 255;
`endif

    logic        clk, nrst, en;
    logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_sel;
    logic        mem_read, mem_write, mem_ack;
    logic [4:0]  rd_address;
    logic        register_write_en;
    logic [31:0] register_write_data;
    logic        misalign_err, bus_err;

    int checks = 0;
    int errors = 0;

    t03_mem_writeback #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(8)) dut (
        .clk(clk), .nrst(nrst), .en(en),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rd_address(rd_address), .register_write_en(register_write_en),
        .register_write_data(register_write_data),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes, 0 for an illegal width code.
    function automatic int unsigned acc_size(input logic [2:0] f3, input bit st);
        case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4: return st ? 0 : 1;
            3'd5: return st ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [2:0] f3, input bit st, input logic [31:0] a);
        int unsigned sz = acc_size(f3, st);
        return (sz != 0) && ((a % sz) == 0);
    endfunction

    function automatic logic [3:0] exp_sel(input int unsigned sz, input logic [31:0] a);
        int unsigned m = ((1 << sz) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] exp_wdata(input int unsigned sz, input logic [31:0] sd);
        logic [31:0] b = sd % 256;
        logic [31:0] h = sd % 65536;
        if (sz == 1) return b * 32'h0101_0101;
        if (sz == 2) return h * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (a % 4));
        int unsigned sz = acc_size(f3, 1'b0);
        if (sz == 1) begin
            v = v % 256;
            if (f3 == 3'd0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic present(input bit ld, input bit st, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] sd);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_rd = rd; ex_alu_result = alu; ex_store_data = sd;
        tick();
        ex_valid = 1'b0;
    endtask

    // One complete op through the stage with en held high; nreq = request cycles (ack in the last).
    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input int unsigned nreq, input logic [31:0] rdata);
        int unsigned sz = acc_size(f3, st);
        check("ready_idle", ex_ready, 1);
        present(ld, st, f3, rd, alu, sd);
        if (!(ld || st)) begin
            check("alu_wen", register_write_en, (rd != 0));
            check("alu_rd", rd_address, rd);
            if (rd != 0) check("alu_data", register_write_data, alu);
            check("alu_ready_low", ex_ready, 0);
            tick();
            check("alu_wen_end", register_write_en, 0);
            check("alu_ready_back", ex_ready, 1);
        end else if (!is_legal(f3, st, alu)) begin
            check("mis_err", misalign_err, 1);
            check("mis_read", mem_read, 0);
            check("mis_write", mem_write, 0);
            check("mis_wen", register_write_en, 0);
            check("mis_ready", ex_ready, 1);
            tick();
            check("mis_err_end", misalign_err, 0);
        end else begin
            for (int unsigned i = 1; i <= nreq; i++) begin
                check("req_read", mem_read, ld);
                check("req_write", mem_write, st);
                check("req_addr", mem_addr, alu - (alu % 4));
                check("req_sel", mem_sel, ld ? 4'hF : exp_sel(sz, alu));
                if (st) check("req_wdata", mem_wdata, exp_wdata(sz, sd));
                check("req_ready", ex_ready, 0);
                check("req_wen", register_write_en, 0);
                if (i == nreq) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
                tick();
                mem_ack = 1'b0;
                mem_rdata = $urandom;
            end
            check("post_read", mem_read, 0);
            check("post_write", mem_write, 0);
            if (ld) begin
                check("ld_wen", register_write_en, (rd != 0));
                check("ld_rd", rd_address, rd);
                if (rd != 0) check("ld_data", register_write_data, exp_load(f3, alu, rdata));
                tick();
                check("ld_wen_end", register_write_en, 0);
                check("ld_ready", ex_ready, 1);
            end else begin
                check("st_wen", register_write_en, 0);
                check("st_ready", ex_ready, 1);
            end
        end
    endtask

    initial begin
        nrst = 1'b0; en = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_funct3 = '0; ex_rd = '0; ex_alu_result = '0; ex_store_data = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        #12;
        check("rst_read", mem_read, 0);
        check("rst_write", mem_write, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_sel", mem_sel, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wen", register_write_en, 0);
        check("rst_rd", rd_address, 0);
        check("rst_wdat", register_write_data, 0);
        check("rst_mis", misalign_err, 0);
        check("rst_bus", bus_err, 0);
        @(negedge clk);
        nrst = 1'b1;
        tick();

        do_op(1'b0, 1'b0, 3'b000, 5'd5, 32'h1234_5678, 32'h0, 1, 32'h0);
        do_op(1'b1, 1'b0, 3'b000, 5'd9, 32'h0000_0103, 32'h0, 3, 32'h80AA_BBCC);
        do_op(1'b1, 1'b0, 3'b100, 5'd9, 32'h0000_0103, 32'h0, 3, 32'h80AA_BBCC);
        do_op(1'b0, 1'b1, 3'b001, 5'd3, 32'h0000_0202, 32'hDEAD_BEEF, 2, 32'h0);
        do_op(1'b1, 1'b0, 3'b010, 5'd4, 32'h0000_0006, 32'h0, 1, 32'h0);
        do_op(1'b0, 1'b0, 3'b000, 5'd0, 32'hA5A5_0001, 32'h0, 1, 32'h0);

        // Ack while stalled is parked and consumed once en returns.
        present(1'b1, 1'b0, 3'b010, 5'd7, 32'h0000_0040, 32'h0);
        check("en_req", mem_read, 1);
        en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        check("en_req_drop", mem_read, 0);
        check("en_wen0", register_write_en, 0);
        check("en_ready0", ex_ready, 0);
        tick();
        check("en_wen1", register_write_en, 0);
        en = 1'b1;
        tick();
        check("en_wb_wen", register_write_en, 1);
        check("en_wb_data", register_write_data, 32'hCAFE_F00D);
        check("en_wb_rd", rd_address, 7);
        en = 1'b0;
        tick();
        check("en_wb_hold", register_write_en, 1);
        en = 1'b1;
        tick();
        check("en_wb_done", register_write_en, 0);
        check("en_ready", ex_ready, 1);

        // Asynchronous reset in the middle of a load.
        present(1'b1, 1'b0, 3'b010, 5'd8, 32'h0000_0080, 32'h0);
        check("rm_req", mem_read, 1);
        #2 nrst = 1'b0;
        #1;
        check("rm_read_drop", mem_read, 0);
        check("rm_addr", mem_addr, 0);
        check("rm_wen", register_write_en, 0);
        #3 nrst = 1'b1;
        tick();
        check("rm_wen_after", register_write_en, 0);
        check("rm_read_after", mem_read, 0);
        check("rm_ready", ex_ready, 1);

`ifdef T03_MEM_TIMEOUT_EN
        present(1'b1, 1'b0, 3'b010, 5'd6, 32'h0000_0100, 32'h0);
        for (int unsigned i = 0; i < TO_CYC; i++) begin
            check("to_req", mem_read, 1);
            check("to_bus_low", bus_err, 0);
            tick();
        end
        check("to_read_drop", mem_read, 0);
        check("to_bus_err", bus_err, 1);
        check("to_wen", register_write_en, 0);
        check("to_ready", ex_ready, 1);
        tick();
        check("to_bus_end", bus_err, 0);
        check("to_wen_end", register_write_en, 0);
`endif

        for (int k = 0; k < 150; k++) begin
            int unsigned kind = $urandom_range(0, 2);
            do_op(kind == 1, kind == 2, 3'($urandom_range(0, 7)), 5'($urandom),
                  $urandom, $urandom, $urandom_range(1, 4), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
